// File: rtl/sync_updown_counter_param.sv
// Synchronous up/down counter with programmable modulus, load, clear and wrap/saturate boundaries.
// Latency: q and wrap register one edge after sampling; tc/at_max/at_min combinational, no backpressure.
module sync_updown_counter_param #(
    parameter int WIDTH     = 4,
    parameter int MAX_VAL   = 2**WIDTH - 1,
    parameter int RESET_VAL = 0,
    parameter bit SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             at_max,
    output logic             at_min
);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $fatal(1, "sync_updown_counter_param: WIDTH must be >= 1");
        end
        if (MAX_VAL < 1 || (64'(MAX_VAL) >> WIDTH) != 64'd0) begin : g_bad_max
            $fatal(1, "sync_updown_counter_param: MAX_VAL must be in 1 .. 2**WIDTH-1");
        end
        if (RESET_VAL < 0 || RESET_VAL > MAX_VAL) begin : g_bad_reset
            $fatal(1, "sync_updown_counter_param: RESET_VAL must be in 0 .. MAX_VAL");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_wrap_nxt;
    logic             w_at_max;
    logic             w_at_min;

    assign w_at_max = (r_q == MAX_Q);
    assign w_at_min = (r_q == '0);

    always_comb begin
        w_q_nxt    = r_q;
        w_wrap_nxt = 1'b0;
        if (clear) begin
            w_q_nxt = RST_Q;
        end else if (load) begin
            w_q_nxt = (load_val > MAX_Q) ? MAX_Q : load_val;
        end else if (en) begin
            if (up_dn) begin
                if (w_at_max) begin
                    w_wrap_nxt = 1'b1;
                    w_q_nxt    = SATURATE ? r_q : '0;
                end else begin
                    w_q_nxt = r_q + WIDTH'(1);
                end
            end else begin
                if (w_at_min) begin
                    w_wrap_nxt = 1'b1;
                    w_q_nxt    = SATURATE ? r_q : MAX_Q;
                end else begin
                    w_q_nxt = r_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q    <= RST_Q;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    // tc looks ahead to the boundary so a cascaded stage steps on the same edge as our wrap.
    assign tc     = en & ((up_dn & w_at_max) | (~up_dn & w_at_min));
    assign q      = r_q;
    assign wrap   = r_wrap;
    assign at_max = w_at_max;
    assign at_min = w_at_min;

endmodule

// File: tb/tb_sync_updown_counter_param.sv
// Directed bench: wrap-mode, saturate-mode and a two-stage decimal cascade built from the counter.
module tb_sync_updown_counter_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Instance A: MAX 9, RESET_VAL 0, wrap mode
    logic       a_reset = 1'b0, a_en = 1'b0, a_up = 1'b1, a_load = 1'b0, a_clear = 1'b0;
    logic [3:0] a_lv = 4'd0;
    logic [3:0] a_q;
    logic       a_tc, a_wrap, a_max, a_min;

    sync_updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(0), .SATURATE(1'b0)) u_a (
        .clk(clk), .reset(a_reset), .en(a_en), .up_dn(a_up), .load(a_load), .load_val(a_lv),
        .clear(a_clear), .q(a_q), .tc(a_tc), .wrap(a_wrap), .at_max(a_max), .at_min(a_min));

    // Instance B: MAX 9, RESET_VAL 2, saturate mode
    logic       b_reset = 1'b0, b_en = 1'b0, b_up = 1'b1, b_load = 1'b0, b_clear = 1'b0;
    logic [3:0] b_lv = 4'd0;
    logic [3:0] b_q;
    logic       b_tc, b_wrap, b_max, b_min;

    sync_updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(2), .SATURATE(1'b1)) u_b (
        .clk(clk), .reset(b_reset), .en(b_en), .up_dn(b_up), .load(b_load), .load_val(b_lv),
        .clear(b_clear), .q(b_q), .tc(b_tc), .wrap(b_wrap), .at_max(b_max), .at_min(b_min));

    // Cascade: low decade tc enables the high decade
    logic       c_reset = 1'b0, c_en = 1'b0;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, lo_wrap, lo_max, lo_min;
    logic       hi_tc, hi_wrap, hi_max, hi_min;

    sync_updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(0), .SATURATE(1'b0)) u_lo (
        .clk(clk), .reset(c_reset), .en(c_en), .up_dn(1'b1), .load(1'b0), .load_val(4'd0),
        .clear(1'b0), .q(lo_q), .tc(lo_tc), .wrap(lo_wrap), .at_max(lo_max), .at_min(lo_min));

    sync_updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(0), .SATURATE(1'b0)) u_hi (
        .clk(clk), .reset(c_reset), .en(lo_tc), .up_dn(1'b1), .load(1'b0), .load_val(4'd0),
        .clear(1'b0), .q(hi_q), .tc(hi_tc), .wrap(hi_wrap), .at_max(hi_max), .at_min(hi_min));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int up_seq[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int dn_seq[4]   = '{1, 0, 9, 8};
    int sat_up[3]   = '{9, 9, 9};
    int sat_upw[3]  = '{0, 1, 1};
    int hi_wraps;
    int prev;

    initial begin
        // ---------------- instance A: reset state ----------------
        a_reset = 1'b1;
        step();
        chk("a_reset_q", a_q, 0);
        chk("a_reset_wrap", a_wrap, 0);
        chk("a_reset_at_min", a_min, 1);
        chk("a_reset_at_max", a_max, 0);

        // ---------------- count up through the 9 -> 0 wrap ----------------
        a_reset = 1'b0; a_en = 1'b1; a_up = 1'b1;
        prev = 0;
        for (int i = 0; i < 12; i++) begin
            #1 chk($sformatf("a_up_tc_%0d", i), a_tc, (prev == 9) ? 1 : 0);
            step();
            chk($sformatf("a_up_q_%0d", i), a_q, up_seq[i]);
            chk($sformatf("a_up_wrap_%0d", i), a_wrap, (i == 9) ? 1 : 0);
            prev = up_seq[i];
        end

        // ---------------- count down through the 0 -> 9 wrap ----------------
        a_up = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("a_dn_tc_%0d", i), a_tc, (prev == 0) ? 1 : 0);
            step();
            chk($sformatf("a_dn_q_%0d", i), a_q, dn_seq[i]);
            chk($sformatf("a_dn_wrap_%0d", i), a_wrap, (i == 2) ? 1 : 0);
            prev = dn_seq[i];
        end

        // ---------------- hold with en low ----------------
        a_en = 1'b0;
        #1 chk("a_hold_tc", a_tc, 0);
        step();
        chk("a_hold_q", a_q, 8);
        chk("a_hold_wrap", a_wrap, 0);

        // ---------------- load, clamp, load beats en ----------------
        a_load = 1'b1; a_lv = 4'd5;
        step();
        chk("a_load5_q", a_q, 5);
        a_lv = 4'd15;
        step();
        chk("a_load15_clamp_q", a_q, 9);
        chk("a_load15_at_max", a_max, 1);
        a_lv = 4'd3; a_en = 1'b1; a_up = 1'b1;
        step();
        chk("a_load_vs_en_q", a_q, 3);

        // ---------------- clear beats load and en ----------------
        a_en = 1'b0; a_lv = 4'd7;
        step();
        chk("a_load7_q", a_q, 7);
        a_clear = 1'b1; a_lv = 4'd2; a_en = 1'b1;
        step();
        chk("a_clear_prio_q", a_q, 0);
        chk("a_clear_prio_wrap", a_wrap, 0);

        // ---------------- reset with clear clears a pending wrap ----------------
        a_clear = 1'b0; a_en = 1'b0; a_lv = 4'd9;
        step();
        a_load = 1'b0; a_en = 1'b1; a_up = 1'b1;
        step();
        chk("a_pre_reset_wrap", a_wrap, 1);
        a_reset = 1'b1; a_clear = 1'b1;
        step();
        chk("a_reset_clear_q", a_q, 0);
        chk("a_reset_clear_wrap", a_wrap, 0);

        // ---------------- reset mid-count ----------------
        a_reset = 1'b0; a_clear = 1'b0; a_en = 1'b0; a_load = 1'b1; a_lv = 4'd6;
        step();
        chk("a_mid_load_q", a_q, 6);
        a_load = 1'b0; a_en = 1'b1; a_reset = 1'b1;
        step();
        chk("a_mid_reset_q", a_q, 0);
        a_reset = 1'b0; a_en = 1'b0;

        // ---------------- instance B: saturate mode ----------------
        b_reset = 1'b1;
        step();
        chk("b_reset_q", b_q, 2);
        chk("b_reset_wrap", b_wrap, 0);
        b_reset = 1'b0; b_load = 1'b1; b_lv = 4'd8;
        step();
        chk("b_load8_q", b_q, 8);
        b_load = 1'b0; b_en = 1'b1; b_up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("b_sat_up_q_%0d", i), b_q, sat_up[i]);
            chk($sformatf("b_sat_up_wrap_%0d", i), b_wrap, sat_upw[i]);
            chk($sformatf("b_sat_up_tc_%0d", i), b_tc, 1);
        end
        b_en = 1'b0; b_load = 1'b1; b_lv = 4'd1;
        step();
        chk("b_load1_q", b_q, 1);
        b_load = 1'b0; b_en = 1'b1; b_up = 1'b0;
        #1 chk("b_dn_tc_at1", b_tc, 0);
        step();
        chk("b_sat_dn_q_0", b_q, 0);
        chk("b_sat_dn_wrap_0", b_wrap, 0);
        chk("b_sat_dn_tc_0", b_tc, 1);
        step();
        chk("b_sat_dn_q_1", b_q, 0);
        chk("b_sat_dn_wrap_1", b_wrap, 1);
        b_clear = 1'b1;
        step();
        chk("b_clear_q", b_q, 2);
        chk("b_clear_wrap", b_wrap, 0);
        b_clear = 1'b0; b_en = 1'b0;

        // ---------------- cascade: 00 .. 99 .. 00 ----------------
        c_reset = 1'b1;
        step();
        chk("c_reset_val", {hi_q, lo_q}, 8'h00);
        c_reset = 1'b0; c_en = 1'b1;
        hi_wraps = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            chk($sformatf("c_cnt_%0d", i), {hi_q, lo_q}, {4'((i + 1) % 100 / 10), 4'((i + 1) % 10)});
            if (hi_wraps < 1000 && hi_wrap === 1'b1) hi_wraps++;
        end
        chk("c_hi_wrap_count", hi_wraps, 1);
        chk("c_hi_wrap_last", hi_wrap, 1);
        c_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
